// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM arbiter/sequencer.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DATA_W = 16;

  localparam logic RR_READ  = 1'b1;
  localparam logic RR_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester ports plus RAM pins; master is the arbiter side, slave the requesters/RAM side.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = ram_ctrl_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = ram_ctrl_pkg::DEF_DATA_W
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              ram_ce;
  logic              ram_rr;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in_data;
  logic [DATA_W-1:0] ram_out_data;

  modport master (
    input  req, we, addr0, addr1, wdata0, wdata1, ram_out_data,
    output gnt, done, rdata, ram_ce, ram_rr, ram_address, ram_in_data
  );

  modport slave (
    output req, we, addr0, addr1, wdata0, wdata1, ram_out_data,
    input  gnt, done, rdata, ram_ce, ram_rr, ram_address, ram_in_data
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker: on contention the port that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       valid
);

  always_comb begin
    valid = |req;
    sel   = req[1];
    if (req == 2'b11) begin
      sel = ~last;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port RAM with read latency RD_LAT.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.master bus
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              idx_q, idx_d;
  logic              we_q, we_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ram_ce_q, ram_ce_d;
  logic              ram_rr_q, ram_rr_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_in_data_q, ram_in_data_d;

  logic arb_sel;
  logic arb_valid;

  rr_arb2 u_arb (
    .req   (bus.req),
    .last  (last_q),
    .sel   (arb_sel),
    .valid (arb_valid)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    idx_d         = idx_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    done_d        = '0;
    rdata_d       = rdata_q;
    ram_ce_d      = 1'b0;
    ram_rr_d      = RR_READ;
    ram_address_d = ram_address_q;
    ram_in_data_d = ram_in_data_q;

    case (state_q)
      IDLE: begin
        // The RAM pins are loaded here so they are already registered during ACCESS.
        if (arb_valid) begin
          state_d        = ACCESS;
          last_d         = arb_sel;
          idx_d          = arb_sel;
          we_d           = bus.we[arb_sel];
          gnt_d[arb_sel] = 1'b1;
          ram_ce_d       = 1'b1;
          ram_rr_d       = bus.we[arb_sel] ? RR_WRITE : RR_READ;
          ram_address_d  = arb_sel ? bus.addr1 : bus.addr0;
          ram_in_data_d  = arb_sel ? bus.wdata1 : bus.wdata0;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d       = IDLE;
          done_d[idx_q] = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d       = IDLE;
          rdata_d       = bus.ram_out_data;
          done_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      idx_q         <= 1'b0;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      rdata_q       <= '0;
      ram_ce_q      <= 1'b0;
      ram_rr_q      <= RR_READ;
      ram_address_q <= '0;
      ram_in_data_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      ram_ce_q      <= ram_ce_d;
      ram_rr_q      <= ram_rr_d;
      ram_address_q <= ram_address_d;
      ram_in_data_q <= ram_in_data_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.ram_ce      = ram_ce_q;
  assign bus.ram_rr      = ram_rr_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_in_data = ram_in_data_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port `RAM` block (ce/rr/address/in_data/out_data). It sits between the instruction-fetch port (port 0) and the load/store port (port 1). It serialises their requests into single RAM accesses, drives the RAM control pins, and returns a per-port completion pulse, plus read data for reads.

## Interface
- `ADDR_W`, 3: RAM address width.
- `DATA_W`, 16: RAM data width.
- `RD_LAT`, 1: clock edges from the RAM access edge until `ram_out_data` is valid; legal range 1..3.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-port request; bit k belongs to port k.
- `we`  in  2  per-port write enable; 1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W  per-port address.
- `wdata0`, `wdata1`  in  DATA_W  per-port write data.
- `gnt`  out  2  one-cycle pulse: the port's request has been latched.
- `done`  out  2  one-cycle pulse: the port's access is complete.
- `rdata`  out  DATA_W  read data; valid while the matching `done` bit is high and the access was a read.
- `ram_ce`  out  1  RAM chip enable.
- `ram_rr`  out  1  RAM read/write select; 1 = read, 0 = write.
- `ram_address`  out  ADDR_W  RAM address.
- `ram_in_data`  out  DATA_W  RAM write data.
- `ram_out_data`  in  DATA_W  RAM read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT.
- **IDLE:**
  - If any `req` bit is high, pick a winner with the round-robin rule.
  - Latch the winner's `we`, `addr`, `wdata` and index, then go to ACCESS.
  - If no `req` bit is high, stay in IDLE.
- **ACCESS:**
  - Drive `ram_ce`=1, `ram_rr`=!latched_we, `ram_address`=latched addr, `ram_in_data`=latched wdata.
  - On a write, go to IDLE and pulse `done[k]`.
  - On a read, load the wait counter with RD_LAT-1 and go to WAIT.
- **WAIT:**
  - Keep `ram_ce`=0 and `ram_rr`=1.
  - Decrement the counter each cycle.
  - At the edge where the counter is 0, capture `ram_out_data` into `rdata`, go to IDLE and pulse `done[k]`.
- **Round-robin rule:**
  - A `last` pointer records the most recently granted port.
  - When both ports request, the port that is not `last` wins.
  - When one port requests, it wins.
  - `last` updates only when a request is latched.
- **Requester protocol:**
  - The requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - It may deassert `req` in the `gnt` cycle, or keep it high to queue the next request.
  - A request withdrawn before it is latched is simply not served.
  - Once latched, an access always completes unless reset intervenes.
- Fields are latched, so changes to a port's inputs after `gnt` do not affect the access in flight.
- `rdata` holds its last captured value between reads; it is not cleared by writes.

## Timing
- **Reset values:**
  - state IDLE, `last`=1 (so port 0 wins the first contention).
  - `gnt`=0, `done`=0, `rdata`=0.
  - `ram_ce`=0, `ram_rr`=1, `ram_address`=0, `ram_in_data`=0.
- All outputs are registered.
- **Write:** req sampled at edge E0; `gnt` and ACCESS in cycle E0→E1. The RAM writes at E1. `done` is high in cycle E1→E2. Occupancy is 2 cycles.
- **Read:** same as a write up to E1. `done`/`rdata` are valid in cycle (E1+RD_LAT)→(E1+RD_LAT+1). Occupancy is 2+RD_LAT cycles.
- **Back-to-back:** IDLE samples `req` in the same cycle that `done` is high. With both ports holding `req`, grants alternate 0,1,0,1…
- **Reset mid-operation:** asserting `rst_n`=0 forces reset values immediately (asynchronously). The in-flight access is dropped with no `done` pulse. The RAM may already have completed a write.
- **Simultaneous events:** `gnt` and `done` never pulse for the same transaction in the same cycle. At most one `gnt` bit and one `done` bit are high per cycle.

## Structure
- Shared package `ram_ctrl_pkg` holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2);
  - RAM op constants RR_READ=1'b1, RR_WRITE=1'b0;
  - default ADDR_W/DATA_W.
- Sub-module `rr_arb2`: combinational two-requester round-robin picker. Inputs are `req[1:0]` and `last`; outputs are `sel` and `valid`. The FSM and all registers stay in `ram_arbiter`.

## Test plan
- **Single write then read, RD_LAT=1:** port 0 writes addr 3 = 16'hAAA3, then reads addr 3. Expect `gnt[0]` one cycle after req; the write `done[0]` 2 cycles after req sampling; the read `done[0]` 3 cycles after sampling with `rdata`=16'hAAA3.
- **Contention:** both ports request reads continuously from reset. Expect grants 0,1,0,1. `ram_ce` is high exactly one cycle per access.
- **Port 1 alone:** port 1 writes addr 7 = 16'h1234 while port 0 is idle. Expect immediate grant to port 1. `ram_rr`=0 and `ram_address`=7 during ACCESS.
- **RD_LAT=3:** a read of addr 5 = 16'hBEEF returns `done` 5 cycles after req sampling with `rdata`=16'hBEEF. A port 1 request arriving during WAIT is not granted until IDLE.
- **Reset mid-read:** `rst_n` is pulled low during WAIT. All outputs go to reset values without a clock, no `done` pulses, and the next request after release is granted to port 0.
- **Withdrawn request:** port 1 raises and drops `req` while port 0 is being served. Expect no `gnt[1]` and no `done[1]`.
